// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, pipeline stall and registered load return.
// Optional REQ timeout with bus error reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              mem_mem_read,
   input  logic              mem_mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              wb_bubble,
   output logic [DATA_W-1:0] load_data,
   output logic              ld_valid,
   output logic              busy,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   access;
   logic   tmo_expire;

   assign access = mem_valid & (mem_mem_read | mem_mem_write);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   // Counter sits at zero outside REQ, so it is already clear on REQ entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (state != REQ) begin
         tmo_cnt <= '0;
      end else if (!dmem_ack) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   // Expiry is only acted on in the ack-less final cycle, so a late ack still wins.
   assign tmo_expire = (state == REQ) & ~dmem_ack & (tmo_cnt == TMO_LAST);

   // The cycle after expiry is always DONE, so this register is the bus_err pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= tmo_expire;
      end
   end

   assign bus_err = err_q;
`else
   assign tmo_expire = 1'b0;
   assign bus_err    = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: defaults come first so no path through the case can infer a latch.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            // Gated by reset so stall reads 0 while reset is held, even with access present.
            stall = access & rst;
            if (access) state_nxt = REQ;
         end
         REQ: begin
            stall = 1'b1;
            if (dmem_ack || tmo_expire) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request fields are captured once at issue and held for the whole REQ phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else if (state == IDLE && access) begin
         dmem_we    <= mem_mem_write;
         dmem_addr  <= mem_addr;
         dmem_wdata <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_data <= '0;
      end else if (state == REQ && dmem_ack && !dmem_we) begin
         load_data <= dmem_rdata;
      end else if (tmo_expire) begin
         load_data <= '0;
      end
   end

   assign dmem_req  = (state == REQ);
   assign ld_valid  = (state == DONE) & ~dmem_we;
   assign busy      = (state != IDLE);
   assign wb_bubble = stall;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected requests/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_ctrl;

   localparam int DW = 32;
   localparam int AW = 32;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      logic          ld_valid;
      logic [DW-1:0] load_data;
      logic          bus_err;
      int            stall_cycles;
      int            req_cycles;
   } cpl_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_valid, mem_mem_read, mem_mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          dmem_req, dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          stall, wb_bubble, ld_valid, busy, bus_err;
   logic [DW-1:0] load_data;

   req_t req_q[$];
   cpl_t cpl_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .wb_bubble(wb_bubble), .load_data(load_data), .ld_valid(ld_valid),
      .busy(busy), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: owns all scoreboard pops.
   req_t cur_req;
   logic in_req   = 1'b0;
   int   stall_cnt = 0;
   int   req_cnt   = 0;

   always @(negedge clk) begin
      if (!rst) begin
         in_req    = 1'b0;
         stall_cnt = 0;
         req_cnt   = 0;
      end else begin
         if (stall) stall_cnt++;
         check("wb_bubble_eq_stall", wb_bubble, stall);
         if (dmem_req) begin
            req_cnt++;
            if (!in_req) begin
               if (req_q.size() == 0) begin
                  check("unexpected_req", 1, 0);
                  cur_req = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata};
               end else begin
                  cur_req = req_q.pop_front();
               end
               in_req = 1'b1;
            end
            check("req_we", dmem_we, cur_req.we);
            check("req_addr", dmem_addr, cur_req.addr);
            check("req_wdata", dmem_wdata, cur_req.wdata);
            check("req_stall", stall, 1);
            check("req_busy", busy, 1);
         end else begin
            in_req = 1'b0;
            if (busy) begin
               if (cpl_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  cpl_t c;
                  c = cpl_q.pop_front();
                  check("done_stall", stall, 0);
                  check("done_ld_valid", ld_valid, c.ld_valid);
                  check("done_load_data", load_data, c.load_data);
                  check("done_bus_err", bus_err, c.bus_err);
                  check("stall_cycles", stall_cnt, c.stall_cycles);
                  check("req_cycles", req_cnt, c.req_cycles);
               end
               stall_cnt = 0;
               req_cnt   = 0;
            end else begin
               check("idle_ld_valid", ld_valid, 0);
               check("idle_bus_err", bus_err, 0);
            end
         end
      end
   end

   // Drives one access; ack_at is the 1-based REQ cycle carrying ack (0 = none), req_len the REQ cycles.
   task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int ack_at, input int req_len,
                            input logic [DW-1:0] rdata, input logic [DW-1:0] exp_ld,
                            input logic exp_err, input bit hold);
      req_t r;
      cpl_t c;
      r.we = wr; r.addr = addr; r.wdata = wdata;
      req_q.push_back(r);
      c.ld_valid = ~wr; c.load_data = exp_ld; c.bus_err = exp_err;
      c.stall_cycles = req_len + 1; c.req_cycles = req_len;
      cpl_q.push_back(c);
      mem_valid = 1'b1; mem_mem_read = rd; mem_mem_write = wr;
      mem_addr = addr; mem_wdata = wdata;
      @(posedge clk); #1;
      for (int i = 1; i <= req_len; i++) begin
         dmem_ack   = (i == ack_at);
         dmem_rdata = (i == ack_at) ? rdata : ~rdata;
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      if (!hold) begin
         mem_valid = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      mem_valid = 1'b1; mem_mem_read = 1'b1; mem_mem_write = 1'b0;
      mem_addr = 32'h0000_0100; mem_wdata = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      #2;
      check("rst_dmem_req", dmem_req, 0);
      check("rst_dmem_we", dmem_we, 0);
      check("rst_dmem_addr", dmem_addr, 0);
      check("rst_dmem_wdata", dmem_wdata, 0);
      check("rst_stall", stall, 0);
      check("rst_load_data", load_data, 0);
      check("rst_ld_valid", ld_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_bus_err", bus_err, 0);
      repeat (2) @(posedge clk);
      #1;
      mem_valid = 1'b0; mem_mem_read = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      // Load with immediate ack.
      do_access(1, 0, 32'h0000_0100, 32'h0, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
      check("idle_after_load", busy, 0);
      // Store with 3 wait cycles; load_data keeps the previous load.
      do_access(0, 1, 32'h0000_0200, 32'h1234_5678, 4, 4, 32'hBAD0_BAD0, 32'hDEAD_BEEF, 0, 0);
      // Back-to-back loads with mem_valid held.
      do_access(1, 0, 32'h0000_0104, 32'h0, 2, 2, 32'h1111_2222, 32'h1111_2222, 0, 1);
      do_access(1, 0, 32'h0000_0108, 32'h0, 1, 1, 32'h0000_0055, 32'h0000_0055, 0, 0);
      // Read and write both set: store wins.
      do_access(1, 1, 32'h0000_020C, 32'hCAFE_F00D, 1, 1, 32'h7777_7777, 32'h0000_0055, 0, 0);

      // Stray ack while idle.
      dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("stray_ack_busy", busy, 0);
      check("stray_ack_load_data", load_data, 32'h0000_0055);

      // Reset in the 2nd REQ cycle, then acks during and after reset.
      req_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0});
      mem_valid = 1'b1; mem_mem_read = 1'b1; mem_mem_write = 1'b0;
      mem_addr = 32'h0000_0300; mem_wdata = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_req", dmem_req, 1);
      rst = 1'b0;
      #1;
      check("midrst_dmem_req", dmem_req, 0);
      check("midrst_stall", stall, 0);
      check("midrst_busy", busy, 0);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      mem_valid = 1'b0; mem_mem_read = 1'b0;
      rst = 1'b1;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("postrst_busy", busy, 0);
      check("postrst_dmem_req", dmem_req, 0);
      check("postrst_load_data", load_data, 0);
      @(posedge clk); #1;

      // Normal load after reset.
      do_access(1, 0, 32'h0000_0400, 32'h0, 3, 3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0);

`ifdef MEM_TIMEOUT_EN
      // No ack: aborted after 4 REQ cycles.
      do_access(1, 0, 32'h0000_0500, 32'h0, 0, 4, 32'h2468_ACE0, 32'h0, 1, 0);
      // Ack in the expiry cycle completes normally.
      do_access(1, 0, 32'h0000_0504, 32'h0, 4, 4, 32'h1357_9BDF, 32'h1357_9BDF, 0, 0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("req_q_drained", req_q.size(), 0);
      check("cpl_q_drained", cpl_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
